// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART serial transmitter.
//
// Sends one byte per frame: a start bit (0), DBIT data bits LSB-first, and a
// stop period (1) that lasts SB_TICK oversampling ticks. Bit timing comes from
// s_tick, a one-clk enable that pulses 16 times per bit period.
//
// Parameters:
//   DBIT     data bits per frame (5..8)
//   SB_TICK  s_tick pulses in the stop period (16 = 1, 24 = 1.5, 32 = 2 bits)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   tx_start      one-clk request to send din; only honoured while idle
//   s_tick        oversampling enable, 16 pulses per bit period
//   din           byte to send, captured on the edge that accepts tx_start
//   tx_done_tick  one-clk pulse in the first idle cycle after a frame
//   tx            registered serial output, idle high
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx_done_tick,
  output logic       tx
);

  // The tick counter must reach SB_TICK-1 in the stop period, so it grows
  // beyond 4 bits for stop periods longer than one bit.
  localparam int SCW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

  localparam logic [SCW-1:0] BIT_LAST  = SCW'(15);
  localparam logic [SCW-1:0] STOP_LAST = SCW'(SB_TICK - 1);
  localparam logic [2:0]     N_LAST    = 3'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SCW-1:0]  s_cnt_q, s_cnt_d;
  logic [2:0]      n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q,     b_d;
  logic            tx_q,    tx_d;
  logic            done_q,  done_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // Next-state and line-value logic. tx_d is the line value of the current
  // state; registering it makes tx lag the state by one clk and keeps the pin
  // glitch-free.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    b_d     = b_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_start) begin
          b_d     = din[DBIT-1:0];
          s_cnt_d = '0;
          state_d = START;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            n_cnt_d = '0;
            state_d = DATA;
          end else begin
            s_cnt_d = s_cnt_q + SCW'(1);
          end
        end
      end

      DATA: begin
        tx_d = b_q[0];
        if (s_tick) begin
          if (s_cnt_q == BIT_LAST) begin
            s_cnt_d = '0;
            b_d     = b_q >> 1;
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + SCW'(1);
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (s_cnt_q == STOP_LAST) begin
            // done_q is high in the first IDLE cycle, where a new tx_start
            // is already accepted, so frames can run back-to-back.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + SCW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// A free-running s_tick (one per 16 clk) drives the DUT. A behavioural UART
// receiver decodes the line by sampling at bit centres and queues received
// bytes; the test compares them with the bytes it asked to send, checks the
// frame length in ticks from acceptance to tx_done_tick, and the pulse count.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DBIT        = 8;
  localparam int SB_TICK     = 16;
  localparam int TICK_DIV    = 16;
  // Ticks consumed after the accepting edge until tx_done_tick rises:
  // 16 for the start bit, 16 per data bit, SB_TICK for the stop period.
  localparam int FRAME_TICKS = 16 + DBIT * 16 + SB_TICK;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       tx_start = 1'b0;
  logic       s_tick   = 1'b0;
  logic [7:0] din      = 8'h00;
  logic       tx_done_tick;
  logic       tx;

  int checks       = 0;
  int errors       = 0;
  int ticks_issued = 0;
  int done_count   = 0;
  bit rx_abort     = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_byte;
  } vec_t;

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .din          (din),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  // s_tick changes on the falling edge so it is stable at the rising edge.
  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      s_tick = (div == TICK_DIV - 1);
      if (s_tick) ticks_issued++;
      div = (div == TICK_DIV - 1) ? 0 : div + 1;
    end
  end

  task automatic tick_sync();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // tx_done_tick must never be high for two consecutive clocks.
  initial begin : done_mon
    logic prev;
    prev = 1'b0;
    forever begin
      tick_sync();
      if (tx_done_tick === 1'b1) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL done_width: tx_done_tick high 2+ clk, required 1 clk");
        end else begin
          done_count++;
        end
      end
      prev = (tx_done_tick === 1'b1);
    end
  end

  // ---------------- behavioural receiver ----------------
  task automatic rx_wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      tick_sync();
      if (reset) rx_abort = 1'b1;
      if (s_tick) k++;
    end
  endtask

  initial begin : rx_mon
    logic       prev;
    logic       start_ok;
    logic [7:0] data;
    prev = 1'b1;
    forever begin
      tick_sync();
      if (!reset && prev === 1'b1 && tx === 1'b0) begin
        rx_abort = 1'b0;
        rx_wait_ticks(8);
        start_ok = (tx === 1'b0);
        data = 8'h00;
        for (int i = 0; i < DBIT; i++) begin
          rx_wait_ticks(16);
          data[i] = tx;
        end
        rx_wait_ticks(8 + SB_TICK / 2);
        if (!rx_abort) begin
          checks++;
          if (!start_ok || tx !== 1'b1) begin
            errors++;
            $display("FAIL rx_framing: start_ok=%0b stop=%0b required start_ok=1 stop=1", start_ok, tx);
          end
          rx_q.push_back(data);
        end
      end
      prev = tx;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a falling edge; the next rising edge samples tx_start.
  task automatic start_frame(input logic [7:0] b, output int base);
    din      = b;
    tx_start = 1'b1;
    base     = ticks_issued;
    tick_sync();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int nticks, output bit seen);
    seen   = 1'b0;
    nticks = -1;
    for (int c = 0; c < 4000 && !seen; c++) begin
      tick_sync();
      if (tx_done_tick === 1'b1) begin
        seen   = 1'b1;
        nticks = ticks_issued - base - (s_tick ? 1 : 0);
      end
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp);
    check({name, "_rx_count"}, rx_q.size(), 1);
    if (rx_q.size() > 0) check({name, "_rx_byte"}, rx_q.pop_front(), exp);
  endtask

  task automatic send_and_check(input string name, input logic [7:0] b, input logic [7:0] exp);
    int base, nticks;
    bit seen;
    start_frame(b, base);
    wait_done(base, nticks, seen);
    check({name, "_done_seen"}, seen, 1);
    check({name, "_frame_ticks"}, nticks, FRAME_TICKS);
    check_rx(name, exp);
    tick_sync();
    check({name, "_idle_line"}, tx, 1);
  endtask

  // ---------------- main test ----------------
  initial begin : main
    vec_t vecs[7];
    int   base, base2, nticks, gap, d0, inj;
    bit   seen, low_seen;
    logic [7:0] b;

    vecs[0] = '{din: 8'h41, exp_byte: 8'h41};
    vecs[1] = '{din: 8'h54, exp_byte: 8'h54};
    vecs[2] = '{din: 8'h0D, exp_byte: 8'h0D};
    vecs[3] = '{din: 8'h0A, exp_byte: 8'h0A};
    vecs[4] = '{din: 8'h00, exp_byte: 8'h00};
    vecs[5] = '{din: 8'hFF, exp_byte: 8'hFF};
    vecs[6] = '{din: 8'hA5, exp_byte: 8'hA5};

    // Reset held with tx_start asserted: line stays idle, nothing starts.
    reset    = 1'b1;
    tx_start = 1'b1;
    din      = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick_sync();
      check("reset_tx", tx, 1);
      check("reset_done", tx_done_tick, 0);
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick_sync();
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("post_reset_line_low", low_seen, 0);
    check("post_reset_done_count", done_count, 0);
    check("post_reset_rx_count", rx_q.size(), 0);

    // Table: "AT\r\n" and boundary data patterns, each sent after the previous done.
    d0 = done_count;
    for (int i = 0; i < 7; i++) begin
      send_and_check($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_byte);
    end
    check("table_done_count", done_count - d0, 7);

    // Busy rejection: a second request mid-frame is ignored.
    d0 = done_count;
    start_frame(8'h54, base);
    while (ticks_issued - base < 50) tick_sync();
    din      = 8'hFF;
    tx_start = 1'b1;
    tick_sync();
    tx_start = 1'b0;
    wait_done(base, nticks, seen);
    check("busy_done_seen", seen, 1);
    check("busy_frame_ticks", nticks, FRAME_TICKS);
    check_rx("busy", 8'h54);
    base2 = ticks_issued;
    while (ticks_issued - base2 < 200) tick_sync();
    check("busy_no_extra_frame", rx_q.size(), 0);
    check("busy_done_count", done_count - d0, 1);

    // Back-to-back: next request issued in the tx_done_tick cycle.
    start_frame(8'h41, base);
    wait_done(base, nticks, seen);
    check("b2b_first_done_seen", seen, 1);
    start_frame(8'h0D, base2);
    gap = 1;
    while (tx !== 1'b0 && gap < 50) begin
      tick_sync();
      gap++;
    end
    check("b2b_done_to_start_clk", gap, 2);
    check_rx("b2b_first", 8'h41);
    wait_done(base2, nticks, seen);
    check("b2b_second_done_seen", seen, 1);
    check("b2b_second_frame_ticks", nticks, FRAME_TICKS);
    check_rx("b2b_second", 8'h0D);
    tick_sync();

    // Reset in the middle of a frame: abort, no done pulse, then recover.
    d0 = done_count;
    start_frame(8'hA5, base);
    while (ticks_issued - base < 60) tick_sync();
    reset = 1'b1;
    tick_sync();
    check("midreset_tx", tx, 1);
    check("midreset_done", tx_done_tick, 0);
    tick_sync();
    tick_sync();
    reset    = 1'b0;
    base2    = ticks_issued;
    low_seen = 1'b0;
    while (ticks_issued - base2 < 130) begin
      tick_sync();
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("midreset_line_low", low_seen, 0);
    check("midreset_done_count", done_count - d0, 0);
    check("midreset_rx_count", rx_q.size(), 0);
    send_and_check("after_reset", 8'h0A, 8'h0A);

    // Random bytes, random idle gaps (0 means back-to-back), occasional
    // ignored mid-frame requests; the expected byte stream is a plain queue.
    for (int f = 0; f < 6; f++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 40);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 150) : -1;
      for (int g = 0; g < gap; g++) tick_sync();
      start_frame(b, base);
      exp_q.push_back(b);
      if (inj >= 0) begin
        while (ticks_issued - base < inj) tick_sync();
        din      = 8'($urandom);
        tx_start = 1'b1;
        tick_sync();
        tx_start = 1'b0;
      end
      wait_done(base, nticks, seen);
      check($sformatf("rand%0d_done_seen", f), seen, 1);
      check($sformatf("rand%0d_frame_ticks", f), nticks, FRAME_TICKS);
      check($sformatf("rand%0d_rx_count", f), rx_q.size(), 1);
      if (rx_q.size() > 0) check($sformatf("rand%0d_rx_byte", f), rx_q.pop_front(), exp_q.pop_front());
    end

    for (int i = 0; i < 40; i++) tick_sync();
    check("final_line_idle", tx, 1);
    check("final_rx_leftover", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
